// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan driver: hex font,
// polarity helpers and index width helper.
package sevseg_pkg;

  // Active-high abcdefg patterns, bit 6 = a ... bit 0 = g, entry 0 in the LSBs
  localparam logic [15:0][6:0] FONT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [6:0] seg_on(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

  // A single-digit display still needs a 1-bit index register
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevseg_hex_font.sv
// Combinational nibble -> seven-segment lookup with output polarity applied.
module sevseg_hex_font
  import sevseg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup, inverted for active-low panels
  always_comb begin
    seg = seg_on(FONT[nib], ACTIVE_LOW);
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with dead-cycle
// anti-ghosting, leading-zero blanking and tear-free frame swap.
// Optional digit blinking is compiled in with `define SEVSEG_BLINK_EN.
module sevenseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
`ifdef SEVSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic DP_OFF = SEG_ACTIVE_LOW;

  logic [PW-1:0]                presc_q, presc_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0][3:0]   act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]        act_dp_q, act_dp_d;
  logic [6:0]                   seg_out_q, seg_out_d;
  logic                         dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]        dig_sel_q, dig_sel_d;
  logic                         frame_tick_q, frame_tick_d;

  logic                         dead;
  logic                         frame_start;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic                         lead;
  logic [NUM_DIGITS-1:0]        onehot;
  logic [3:0]                   cur_nib;
  logic                         cur_dp;
  logic [6:0]                   font_seg;
  logic                         blink_off;

  // Slot 0 of every digit is the dead cycle; slot 0 of digit 0 starts a frame
  assign dead        = (presc_q == '0);
  assign frame_start = en && dead && (idx_q == '0);
  assign onehot      = NUM_DIGITS'(1) << idx_q;
  assign cur_nib     = act_data_q[idx_q];
  assign cur_dp      = act_dp_q[idx_q];

  sevseg_hex_font #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_font (
    .nib (cur_nib),
    .seg (font_seg)
  );

  // Prescaler and digit index; the index steps as the prescaler wraps so the
  // dead cycle already carries the new digit number
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (en) begin
      if (presc_q == P_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Shadow takes every load; active swaps only at frame start, taking a
  // coincident load directly so it shows in the frame just starting
  always_comb begin
    shadow_data_d = load ? data_in : shadow_data_q;
    shadow_dp_d   = load ? dp_in : shadow_dp_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    if (frame_start) begin
      act_data_d = load ? data_in : shadow_data_q;
      act_dp_d   = load ? dp_in : shadow_dp_q;
    end
  end

  // Leading zeros from the top digit down to the first nonzero; digit 0 always shown
  always_comb begin
    lz_blank = '0;
    lead     = blank_lz;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (lead && (act_data_q[d] == 4'h0)) lz_blank[d] = 1'b1;
      else                                 lead        = 1'b0;
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BFW-1:0] BF_LAST = BFW'(BLINK_FRAMES - 1);

  logic [BFW-1:0] bcnt_q, bcnt_d;
  logic           phase_q, phase_d;

  // Count frame starts; flip the blink phase every BLINK_FRAMES of them
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (bcnt_q == BF_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_off = phase_q && blink_mask[idx_q];
`else
  assign blink_off = 1'b0;
`endif

  // Next output values: dark unless scanning in a live slot; LZ blanking
  // hides segments only, blinking hides the whole digit including dp
  always_comb begin
    seg_out_d    = seg_off(SEG_ACTIVE_LOW);
    dp_out_d     = DP_OFF;
    dig_sel_d    = DIG_OFF;
    frame_tick_d = frame_start;
    if (en && !dead && !blink_off) begin
      dig_sel_d = onehot ^ DIG_OFF;
      dp_out_d  = cur_dp ^ DP_OFF;
      if (!lz_blank[idx_q]) seg_out_d = font_seg;
    end
  end

  // Scan state and frame buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
    end
  end

  // Registered pin outputs, forced dark by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_q    <= seg_off(SEG_ACTIVE_LOW);
      dp_out_q     <= DP_OFF;
      dig_sel_q    <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      seg_out_q    <= seg_out_d;
      dp_out_q     <= dp_out_d;
      dig_sel_q    <= dig_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign dp_out     = dp_out_q;
  assign dig_sel    = dig_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (4 digits, 4-cycle slots,
// active-low segments and digit selects). Blink frames are checked too
// when built with SEVSEG_BLINK_EN.
module tb_sevenseg_scan_driver;

  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S4  = 7'b1001100;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SB  = 7'b1100000;
  localparam logic [6:0] SC  = 7'b0110001;
  localparam logic [6:0] SD  = 7'b1000010;

`ifdef SEVSEG_BLINK_EN
  localparam int NF = 6;
`else
  localparam int NF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
`ifdef SEVSEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  sevenseg_scan_driver #(
    .NUM_DIGITS     (4),
    .PRESCALE       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
`ifdef SEVSEG_BLINK_EN
    ,
    .BLINK_FRAMES   (2)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
`ifdef SEVSEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; sample point is 1 time unit after the edge; load is a one-cycle strobe
  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      seen = frame_tick;
    end
    check(tag, seen, 1'b1);
  endtask

  // Entered on the frame_tick sample; walks all four 4-cycle slots
  task automatic expect_frame(input string tag, input logic [3:0][6:0] segs,
                              input logic [3:0] dps, input logic [3:0] dark);
    logic [3:0] exp_sel;
    logic       exp_dp;
    for (int d = 0; d < 4; d++) begin
      if (d != 0) step();
      check($sformatf("%s d%0d dead sel", tag, d), dig_sel, 4'hF);
      check($sformatf("%s d%0d dead seg", tag, d), seg_out, OFF);
      for (int k = 0; k < 3; k++) begin
        step();
        exp_sel = dark[d] ? 4'hF : ~(4'b0001 << d);
        exp_dp  = dark[d] ? 1'b1 : ~dps[d];
        check($sformatf("%s d%0d sel", tag, d), dig_sel, exp_sel);
        check($sformatf("%s d%0d seg", tag, d), seg_out, segs[d]);
        check($sformatf("%s d%0d dp", tag, d), dp_out, exp_dp);
        check($sformatf("%s d%0d tick", tag, d), frame_tick, 1'b0);
      end
    end
  endtask

  initial begin
    logic [3:0] dk;
    int         n;
    logic       seen;

    step();
    step();
    check("reset seg", seg_out, OFF);
    check("reset sel", dig_sel, 4'hF);
    check("reset dp", dp_out, 1'b1);
    check("reset tick", frame_tick, 1'b0);

    // Basic scan of 1234
    rst_n = 1'b1;
    data_in = 16'h1234; dp_in = 4'b0000; load = 1'b1; en = 1'b1;
    wait_frame("t2 tick");
    expect_frame("t2", {S1, S2, S3, S4}, 4'b0000, 4'b0000);

    // Mid-frame load stays hidden until the next frame
    step();
    check("t4 tick a", frame_tick, 1'b1);
    data_in = 16'hABCD; load = 1'b1;
    expect_frame("t4 old", {S1, S2, S3, S4}, 4'b0000, 4'b0000);
    step();
    check("t4 tick b", frame_tick, 1'b1);
    expect_frame("t4 new", {SA, SB, SC, SD}, 4'b0000, 4'b0000);

    // Load on the frame-start cycle shows in that same frame
    data_in = 16'h1234; load = 1'b1;
    step();
    check("t4 tick c", frame_tick, 1'b1);
    expect_frame("t4 bypass", {S1, S2, S3, S4}, 4'b0000, 4'b0000);

    // Leading-zero blanking; dp of a blanked digit still lit
    data_in = 16'h0070; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
    step();
    check("t3 tick a", frame_tick, 1'b1);
    expect_frame("t3 lz", {OFF, OFF, S7, S0}, 4'b1000, 4'b0000);
    blank_lz = 1'b0;
    step();
    check("t3 tick b", frame_tick, 1'b1);
    expect_frame("t3 nolz", {S0, S0, S7, S0}, 4'b1000, 4'b0000);

    // Interior zero after the first nonzero digit is not blanked
    data_in = 16'h0105; dp_in = 4'b0000; blank_lz = 1'b1; load = 1'b1;
    step();
    check("t3 tick c", frame_tick, 1'b1);
    expect_frame("t3 inner", {OFF, S1, S0, S5}, 4'b0000, 4'b0000);

    // Pause at prescaler 2 of digit 1 and resume
    blank_lz = 1'b0;
    step();
    check("t5 tick a", frame_tick, 1'b1);
    repeat (5) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5 dark sel", dig_sel, 4'hF);
      check("t5 dark seg", seg_out, OFF);
      check("t5 dark tick", frame_tick, 1'b0);
    end
    en = 1'b1;
    step();
    check("t5 resume sel a", dig_sel, 4'b1101);
    check("t5 resume seg a", seg_out, S0);
    step();
    check("t5 resume sel b", dig_sel, 4'b1101);
    step();
    check("t5 resume dead", dig_sel, 4'hF);
    check("t5 resume tick", frame_tick, 1'b0);
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      seen = frame_tick;
    end
    check("t5 tick delay", n, 8);

    // Reset in the middle of a lit slot darkens outputs at once
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t1 seg", seg_out, OFF);
    check("t1 sel", dig_sel, 4'hF);
    check("t1 dp", dp_out, 1'b1);
    check("t1 tick", frame_tick, 1'b0);
    step();
    rst_n = 1'b1;
    data_in = 16'h1234; dp_in = 4'b0001; load = 1'b1;
`ifdef SEVSEG_BLINK_EN
    blink_mask = 4'b0011;
`endif
    step();
    check("t1 restart tick", frame_tick, 1'b1);

    // Frames after restart; with blinking, digits 0,1 dark in frames 2,3,6
    for (int f = 1; f <= NF; f++) begin
      if (f > 1) begin
        step();
        check("t6 tick", frame_tick, 1'b1);
      end
      dk = 4'b0000;
`ifdef SEVSEG_BLINK_EN
      if (((f / 2) % 2) == 1) dk = 4'b0011;
`endif
      expect_frame($sformatf("t6 f%0d", f),
                   {S1, S2, dk[1] ? OFF : S3, dk[0] ? OFF : S4}, 4'b0001, dk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display. It is the parametrised successor of the single-digit BCD/hex decoder. It latches a packed BCD/hex word and per-digit decimal points, and scans one digit at a time with a programmable refresh rate and an anti-ghosting dead cycle. It applies optional leading-zero blanking and swaps frames tear-free. It sits between the clock/alarm time registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
PRESCALE, 1000, clk cycles per digit slot (>=2); counter width $clog2(PRESCALE).
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs driven low to light.
DIG_ACTIVE_LOW, 1, 1 = dig_sel outputs driven low to enable a digit.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low = display dark, counters hold
load  input  1  single-cycle strobe: capture data_in/dp_in into shadow buffer
data_in  input  4*NUM_DIGITS  packed nibbles, digit 0 (least significant) in [3:0]
dp_in  input  NUM_DIGITS  decimal point per digit
blank_lz  input  1  leading-zero blanking enable
seg_out  output  7  segments, bit 6 = a ... bit 0 = g
dp_out  output  1  decimal point of current digit
dig_sel  output  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
frame_tick  output  1  one-cycle pulse at start of each frame (digit 0 slot)

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are registered. Reset values:
  - seg_out = all segments off (7'h7F when SEG_ACTIVE_LOW).
  - dp_out = off.
  - dig_sel = all digits off.
  - frame_tick = 0.
  - Prescaler = 0, digit index = 0, shadow and active buffers = 0.
- Font: hex 0-F, abcdefg order:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000,
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - The active-high table is inverted when SEG_ACTIVE_LOW=1.
- Slot timing: the prescaler counts 0..PRESCALE-1 and wraps.
  - Prescaler=0 is the dead cycle: dig_sel all off, seg_out off.
  - Prescaler 1..PRESCALE-1: the current digit is selected and its segments are driven.
  - Outputs lag the internal state by one register stage.
- Digit index advances on the dead cycle, wrapping from NUM_DIGITS-1 to 0. Scan order is 0,1,...,N-1.
- Frame start is the dead cycle entering index 0:
  - frame_tick=1 for that single cycle.
  - The active buffer is copied from the shadow buffer.
- load writes the shadow buffer only; the visible digits change only at the next frame start (tear-free).
- If load coincides with the frame-start cycle, the newly loaded data bypasses into the active buffer directly.
- Leading-zero blanking (blank_lz=1): starting from digit NUM_DIGITS-1 downward, digits equal to 0 are blanked until the first nonzero digit.
  - Digit 0 is never blanked.
  - dp of a blanked digit still follows dp_in.
  - blank_lz is sampled combinationally against the active buffer.
- en=0:
  - Outputs go dark on the next cycle.
  - Prescaler and index hold; frame_tick=0.
  - load is still accepted into the shadow buffer.
  - When en returns high, scanning resumes from the held state.
- Reset mid-scan forces the reset values immediately; there is no partial-slot output after release.

Optional Feature:
SEVSEG_BLINK_EN
- Defined:
  - Adds input blink_mask [NUM_DIGITS] and parameter BLINK_FRAMES (default 64).
  - A blink phase flop toggles every BLINK_FRAMES frame_ticks; it resets to 0.
  - While the phase is 1, digits whose mask bit is set are blanked, including dp. This serves alarm/time-set indication.
- Undefined: no port, no counter, no blanking from this source.

Decomposition:
- Package sevseg_pkg holds:
  - The 16-entry abcdefg font constant (active-high).
  - SEG_OFF/SEG_ON polarity helper functions.
  - The digit-index width function.
- Sub-module sevseg_hex_font: purely combinational nibble -> 7-bit lookup with a polarity parameter, instantiated once on the muxed nibble.

Test Plan:
1. Assert rst_n=0 mid-scan (params 4/4/1/1) -> immediately seg_out=7'h7F, dig_sel=4'b1111, dp_out=1, frame_tick=0.
2. load data_in=16'h1234, dp_in=0, en=1 -> after next frame_tick, per 4-cycle slot:
   - 1 dead cycle with dig_sel=1111.
   - Then 3 cycles of dig_sel=1110 with seg=7'b1001100 ('4').
   - Then digits '3', '2', '1' on dig_sel 1101/1011/0111.
3. data_in=16'h0070, blank_lz=1 -> digits 3,2 seg=7'h7F; digit 1 seg=7'b0001111; digit 0 seg=7'b0000001. With blank_lz=0, digits 3,2 show 7'b0000001.
4. load 16'hABCD mid-frame while 16'h1234 is shown -> remaining slots of the current frame still show 1234; the new value appears from the next frame_tick. A load on the frame_tick cycle itself shows the new value in that same frame.
5. Deassert en for 10 cycles at prescaler=2, index=1 -> outputs dark on the next cycle. On re-enable, index 1 resumes with the prescaler continuing from 2, and no extra frame_tick occurs.
6. With SEVSEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0011 -> digits 0,1 are dark on alternate 2-frame windows; digits 2,3 are never affected.
